// File: rtl/div_iterative.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, start/busy/done handshake.
// Unsigned or two's-complement operands; signed results truncate toward zero.
module div_iterative #(
    parameter int    N_WIDTH = 8,
    parameter int    D_WIDTH = 8,
    parameter string SIGNED  = "FALSE"
) (
    input  logic               arst,
    input  logic               clk,
    input  logic               start,
    input  logic [N_WIDTH-1:0] n,
    input  logic [D_WIDTH-1:0] d,
    output logic               busy,
    output logic               done,
    output logic [N_WIDTH-1:0] q,
    output logic [D_WIDTH-1:0] r,
    output logic               div_by_zero
);

    localparam bit IS_SIGNED = (SIGNED == "TRUE");
    localparam int CNT_W     = $clog2(N_WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    // Magnitudes use one extra bit so the most-negative operand is representable.
    function automatic logic [N_WIDTH-1:0] mag_n(input logic [N_WIDTH-1:0] v);
        logic signed [N_WIDTH:0] ext;
        ext = {IS_SIGNED & v[N_WIDTH-1], v};
        if (ext[N_WIDTH])
            ext = -ext;
        return ext[N_WIDTH-1:0];
    endfunction

    function automatic logic [D_WIDTH-1:0] mag_d(input logic [D_WIDTH-1:0] v);
        logic signed [D_WIDTH:0] ext;
        ext = {IS_SIGNED & v[D_WIDTH-1], v};
        if (ext[D_WIDTH])
            ext = -ext;
        return ext[D_WIDTH-1:0];
    endfunction

    function automatic logic [N_WIDTH-1:0] sign_n(input logic [N_WIDTH-1:0] v, input logic neg);
        logic signed [N_WIDTH-1:0] s;
        s = v;
        return neg ? -s : s;
    endfunction

    function automatic logic [D_WIDTH-1:0] sign_d(input logic [D_WIDTH-1:0] v, input logic neg);
        logic signed [D_WIDTH-1:0] s;
        s = v;
        return neg ? -s : s;
    endfunction

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q;
    logic               neg_r;
    logic               dz;

    logic [D_WIDTH-1:0] rem;
    logic [N_WIDTH-1:0] nq;
    logic [D_WIDTH-1:0] dmag;
    logic [D_WIDTH-1:0] n_lo;

    logic [D_WIDTH:0]   partial;
    logic [D_WIDTH:0]   diff;
    logic               ge;
    logic [D_WIDTH-1:0] rem_next;

    assign busy = (state != S_IDLE);

    // Restoring step: bring in the next dividend bit, subtract the divisor if it fits.
    always_comb begin
        partial  = {rem, nq[N_WIDTH-1]};
        diff     = partial - {1'b0, dmag};
        ge       = (partial >= {1'b0, dmag});
        rem_next = ge ? diff[D_WIDTH-1:0] : partial[D_WIDTH-1:0];
    end

    // Datapath: nq shifts dividend bits out the top and quotient bits in at the bottom.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            rem  <= '0;
            nq   <= mag_n(n);
            dmag <= mag_d(d);
            n_lo <= n[D_WIDTH-1:0];
        end else if (state == S_CALC) begin
            rem <= rem_next;
            nq  <= {nq[N_WIDTH-2:0], ge};
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CALC;
                        cnt   <= CNT_W'(N_WIDTH);
                        neg_r <= IS_SIGNED & n[N_WIDTH-1];
                        neg_q <= IS_SIGNED & (n[N_WIDTH-1] ^ d[D_WIDTH-1]);
                        dz    <= (d == '0);
                    end
                end
                S_CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= S_FIN;
                end
                S_FIN: begin
                    state       <= S_IDLE;
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    // Divide-by-zero results are forced rather than taken from the datapath.
                    if (dz) begin
                        q <= '1;
                        r <= n_lo;
                    end else begin
                        q <= sign_n(nq, neg_q);
                        r <= sign_d(rem, neg_r);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iterative.sv
// Bench for div_iterative: unsigned 8/8, signed 8/8 and unsigned 16/8 instances,
// table-driven operations scored through per-instance expectation queues.
module tb_div_iterative;

    typedef struct {
        int          inst;
        logic [15:0] n;
        logic [7:0]  d;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          due;
    } exp_t;

    logic clk;
    logic arst;
    int   cyc;
    int   checks;
    int   errors;

    logic       start_u, start_s, start_w;
    logic [7:0] n_u, n_s, d_u, d_s, d_w;
    logic [15:0] n_w;
    logic       busy_u, busy_s, busy_w, done_u, done_s, done_w;
    logic [7:0] q_u, q_s, r_u, r_s, r_w;
    logic [15:0] q_w;
    logic       dz_u, dz_s, dz_w;
    logic       prev_u, prev_s, prev_w;

    exp_t sb_u[$];
    exp_t sb_s[$];
    exp_t sb_w[$];

    div_iterative #(.N_WIDTH(8), .D_WIDTH(8), .SIGNED("FALSE")) u_u8 (
        .arst(arst), .clk(clk), .start(start_u), .n(n_u), .d(d_u),
        .busy(busy_u), .done(done_u), .q(q_u), .r(r_u), .div_by_zero(dz_u));

    div_iterative #(.N_WIDTH(8), .D_WIDTH(8), .SIGNED("TRUE")) u_s8 (
        .arst(arst), .clk(clk), .start(start_s), .n(n_s), .d(d_s),
        .busy(busy_s), .done(done_s), .q(q_s), .r(r_s), .div_by_zero(dz_s));

    div_iterative #(.N_WIDTH(16), .D_WIDTH(8), .SIGNED("FALSE")) u_w16 (
        .arst(arst), .clk(clk), .start(start_w), .n(n_w), .d(d_w),
        .busy(busy_w), .done(done_w), .q(q_w), .r(r_w), .div_by_zero(dz_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int lat(input int inst);
        return (inst == 2) ? 17 : 9;
    endfunction

    function automatic logic busy_of(input int inst);
        case (inst)
            0:       return busy_u;
            1:       return busy_s;
            default: return busy_w;
        endcase
    endfunction

    task automatic score(input int inst, input logic [15:0] qa, input logic [7:0] ra, input logic dza);
        exp_t  e;
        int    sz;
        string tag;
        tag = (inst == 0) ? "u8" : (inst == 1) ? "s8" : "w16";
        sz  = (inst == 0) ? sb_u.size() : (inst == 1) ? sb_s.size() : sb_w.size();
        if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_done: got done=1, expected no done (cycle %0d)", tag, cyc);
        end else begin
            case (inst)
                0:       e = sb_u.pop_front();
                1:       e = sb_s.pop_front();
                default: e = sb_w.pop_front();
            endcase
            chk({tag, "_q"}, {16'd0, qa}, {16'd0, e.q});
            chk({tag, "_r"}, {24'd0, ra}, {24'd0, e.r});
            chk({tag, "_div_by_zero"}, {31'd0, dza}, {31'd0, e.dz});
            chk({tag, "_latency"}, cyc, e.due);
        end
    endtask

    // Scoreboard side: every done pops one expectation; back-to-back done is an error.
    always @(negedge clk) begin
        if (done_u) score(0, {8'd0, q_u}, r_u, dz_u);
        if (done_s) score(1, {8'd0, q_s}, r_s, dz_s);
        if (done_w) score(2, q_w, r_w, dz_w);
        if ((done_u && prev_u) || (done_s && prev_s) || (done_w && prev_w)) begin
            checks++;
            errors++;
            $display("FAIL done_twice: got done high two cycles running, expected single pulse (cycle %0d)", cyc);
        end
        prev_u = done_u;
        prev_s = done_s;
        prev_w = done_w;
    end

    task automatic wait_idle(input int inst);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy_of(inst)) return;
        end
        chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb_u.size() == 0 && sb_s.size() == 0 && sb_w.size() == 0) return;
        end
        chk("drain_timeout", 32'd1, 32'd0);
    endtask

    // Drive one start pulse; the expectation is queued as the stimulus goes out.
    task automatic op(input int inst, input logic [15:0] nn, input logic [7:0] dd,
                      input logic [15:0] eq, input logic [7:0] er, input logic edz);
        exp_t e;
        wait_idle(inst);
        e.q   = eq;
        e.r   = er;
        e.dz  = edz;
        e.due = cyc + 1 + lat(inst);
        case (inst)
            0: begin start_u = 1'b1; n_u = nn[7:0]; d_u = dd; sb_u.push_back(e); end
            1: begin start_s = 1'b1; n_s = nn[7:0]; d_s = dd; sb_s.push_back(e); end
            default: begin start_w = 1'b1; n_w = nn; d_w = dd; sb_w.push_back(e); end
        endcase
        @(negedge clk);
        start_u = 1'b0;
        start_s = 1'b0;
        start_w = 1'b0;
    endtask

    vec_t tbl [0:23];

    initial begin
        logic [15:0] rn;
        logic [7:0]  rd;
        exp_t        e;
        int          k;

        tbl[0]  = '{0, 16'd200,   8'd7,    16'd28,    8'd4,    1'b0};
        tbl[1]  = '{0, 16'd255,   8'd1,    16'd255,   8'd0,    1'b0};
        tbl[2]  = '{0, 16'd3,     8'd200,  16'd0,     8'd3,    1'b0};
        tbl[3]  = '{0, 16'd0,     8'd9,    16'd0,     8'd0,    1'b0};
        tbl[4]  = '{0, 16'd255,   8'd255,  16'd1,     8'd0,    1'b0};
        tbl[5]  = '{0, 16'd128,   8'd3,    16'd42,    8'd2,    1'b0};
        tbl[6]  = '{0, 16'd55,    8'd0,    16'hFF,    8'h37,   1'b1};
        tbl[7]  = '{0, 16'd9,     8'd3,    16'd3,     8'd0,    1'b0};
        tbl[8]  = '{1, 16'h9C,    8'h07,   16'hF2,    8'hFE,   1'b0};
        tbl[9]  = '{1, 16'h64,    8'hF9,   16'hF2,    8'h02,   1'b0};
        tbl[10] = '{1, 16'h80,    8'hFF,   16'h80,    8'h00,   1'b0};
        tbl[11] = '{1, 16'h80,    8'h01,   16'h80,    8'h00,   1'b0};
        tbl[12] = '{1, 16'h07,    8'hFE,   16'hFD,    8'h01,   1'b0};
        tbl[13] = '{1, 16'hF9,    8'h02,   16'hFD,    8'hFF,   1'b0};
        tbl[14] = '{1, 16'hFF,    8'h80,   16'h00,    8'hFF,   1'b0};
        tbl[15] = '{1, 16'h7F,    8'h80,   16'h00,    8'h7F,   1'b0};
        tbl[16] = '{1, 16'h80,    8'h80,   16'h01,    8'h00,   1'b0};
        tbl[17] = '{1, 16'h9C,    8'h00,   16'hFF,    8'h9C,   1'b1};
        tbl[18] = '{2, 16'hFFFF,  8'hFF,   16'd257,   8'd0,    1'b0};
        tbl[19] = '{2, 16'd1000,  8'd7,    16'd142,   8'd6,    1'b0};
        tbl[20] = '{2, 16'd40000, 8'd200,  16'd200,   8'd0,    1'b0};
        tbl[21] = '{2, 16'd12345, 8'd100,  16'd123,   8'd45,   1'b0};
        tbl[22] = '{2, 16'hFFFF,  8'd1,    16'hFFFF,  8'd0,    1'b0};
        tbl[23] = '{2, 16'h1234,  8'd0,    16'hFFFF,  8'h34,   1'b1};

        checks = 0;
        errors = 0;
        cyc    = 0;
        prev_u = 1'b0; prev_s = 1'b0; prev_w = 1'b0;
        start_u = 1'b0; start_s = 1'b0; start_w = 1'b0;
        n_u = '0; n_s = '0; n_w = '0; d_u = '0; d_s = '0; d_w = '0;
        arst = 1'b1;

        #1;
        chk("reset_busy", {31'd0, busy_u}, 32'd0);
        chk("reset_done", {31'd0, done_u}, 32'd0);
        chk("reset_q", {24'd0, q_u}, 32'd0);
        chk("reset_r", {24'd0, r_u}, 32'd0);
        chk("reset_div_by_zero", {31'd0, dz_u}, 32'd0);
        @(negedge clk);
        arst = 1'b0;

        // Busy profile around a single operation: high right after accept through the FIN cycle.
        op(0, 16'd200, 8'd7, 16'd28, 8'd4, 1'b0);
        chk("busy_after_accept", {31'd0, busy_u}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("busy_during_calc", {31'd0, busy_u}, 32'd1);
        end
        @(negedge clk);
        chk("busy_in_done_cycle", {31'd0, busy_u}, 32'd0);
        chk("done_in_done_cycle", {31'd0, done_u}, 32'd1);

        for (int i = 0; i < 24; i++)
            op(tbl[i].inst, tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].r, tbl[i].dz);
        wait_drain();

        // Start held high: accepted every 10 cycles, including in each done cycle.
        wait_idle(0);
        k = cyc;
        for (int i = 0; i < 3; i++) begin
            e.q = 16'd3; e.r = 8'd2; e.dz = 1'b0; e.due = k + 10 + 10 * i;
            sb_u.push_back(e);
        end
        start_u = 1'b1; n_u = 8'd17; d_u = 8'd5;
        for (int t = 1; t <= 21; t++) begin
            @(negedge clk);
            if ((t % 10) >= 2 && (t % 10) <= 7) begin
                n_u = 8'd99; d_u = 8'd2;
            end else begin
                n_u = 8'd17; d_u = 8'd5;
            end
        end
        start_u = 1'b0;
        wait_drain();

        // Abort mid-operation; the aborted op must never produce done.
        wait_idle(0);
        start_u = 1'b1; n_u = 8'd100; d_u = 8'd3;
        @(negedge clk);
        start_u = 1'b0;
        repeat (3) @(negedge clk);
        arst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy_u}, 32'd0);
        chk("abort_done", {31'd0, done_u}, 32'd0);
        chk("abort_q", {24'd0, q_u}, 32'd0);
        chk("abort_r", {24'd0, r_u}, 32'd0);
        chk("abort_div_by_zero", {31'd0, dz_u}, 32'd0);
        @(negedge clk);
        arst = 1'b0;
        op(0, 16'd255, 8'd16, 16'd15, 8'd15, 1'b0);
        wait_drain();

        for (int i = 0; i < 16; i++) begin
            rn = 16'($urandom_range(0, 255));
            rd = 8'($urandom_range(1, 255));
            op(0, rn, rd, rn / {8'd0, rd}, 8'(rn % {8'd0, rd}), 1'b0);
        end
        wait_drain();
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, expected completion");
        $fatal(1);
    end

endmodule
